fifo_wr_arbiter: RTL and testbench

- Shares one 64-entry circular synchronous FIFO between NUM_REQ producers. Each producer uses a valid/ready port.
- Round-robin arbitration with a bounded burst: a requester keeps the grant for up to BURST_MAX consecutive writes.
- Drives the FIFO write_en/buf_in and keeps its own credit count of free entries, so no write is ever issued into a full FIFO.
- Does not depend on the FIFO's registered buffer_full, which lags count by one cycle. Sits directly in front of the FIFO write port; the consumer reports pops back to it.

---
 rtl/fifo_arb_pkg.sv | 21 ++
 rtl/fifo_wr_arbiter_if.sv | 33 +++
 rtl/rr_pick.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 123 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-side arbiter and its helpers.
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   localparam int FIFO_DEPTH  = 64;
   localparam int FIFO_DATA_W = 8;
   localparam int FIFO_CNT_W  = 7;

   // Width of the burst counter; covers BURST_MAX up to 15.
   localparam int BURST_W = 4;

   // Index width for n items, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake, FIFO write port and credit status of the write arbiter.
interface fifo_wr_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = FIFO_DATA_W,
   parameter int CNT_W   = FIFO_CNT_W,
   parameter int ID_W    = clog2_min1(NUM_REQ)
);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      fifo_pop;
   logic                      fifo_write_en;
   logic [DATA_W-1:0]         fifo_buf_in;
   logic [ID_W-1:0]           grant_id;
   logic [CNT_W-1:0]          credits;
   logic                      credit_err;

   // Arbiter side: owns the FIFO write port and the producer ready lines.
   modport master (
      input  req_valid, req_data, fifo_pop,
      output req_ready, fifo_write_en, fifo_buf_in, grant_id, credits, credit_err
   );

   // Producer/consumer side.
   modport slave (
      output req_valid, req_data, fifo_pop,
      input  req_ready, fifo_write_en, fifo_buf_in, grant_id, credits, credit_err
   );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set bit of req after position last.
module rr_pick #(
   parameter int N    = 4,
   parameter int ID_W = 2
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] last,
   output logic [ID_W-1:0] winner,
   output logic            any
);

   int   idx;
   logic found;

   // Scan last+1, last+2, ... wrapping; last itself is checked last.
   always_comb begin
      // NOTE: every output and temporary gets a default first so no latch is inferred.
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      any    = |req;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(last) + k) % N;
         if (!found && req[idx]) begin
            winner = ID_W'(idx);
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited write arbiter in front of a shared FIFO.
// Tracks free FIFO entries with its own credit counter so it never writes
// into a full FIFO, independent of the FIFO's lagging full flag.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = FIFO_DATA_W,
   parameter int DEPTH     = FIFO_DEPTH,
   parameter int CNT_W     = FIFO_CNT_W,
   parameter int BURST_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   fifo_wr_arbiter_if.master bus
);

   localparam int ID_W = clog2_min1(NUM_REQ);

   localparam logic [0:0] S_IDLE  = 1'(IDLE);
   localparam logic [0:0] S_BURST = 1'(BURST);

   logic [0:0]         state_q, state_d;
   logic [ID_W-1:0]    last_grant_q, last_grant_d;
   logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
   logic [CNT_W-1:0]   credits_q, credits_d;
   logic               credit_err_q, credit_err_d;
   logic               write_en_q, write_en_d;
   logic [DATA_W-1:0]  buf_in_q, buf_in_d;
   logic [ID_W-1:0]    grant_id_q, grant_id_d;

   logic [ID_W-1:0]    rr_winner;
   logic               any_valid;
   logic [ID_W-1:0]    winner;
   logic               keep_owner;
   logic               accept;
   logic               at_depth;

   rr_pick #(
      .N    (NUM_REQ),
      .ID_W (ID_W)
   ) u_rr_pick (
      .req    (bus.req_valid),
      .last   (last_grant_q),
      .winner (rr_winner),
      .any    (any_valid)
   );

   // Pick this cycle's winner; the owner keeps priority until its burst is spent.
   always_comb begin
      keep_owner = (state_q == S_BURST) && bus.req_valid[last_grant_q] &&
                   (burst_cnt_q < BURST_W'(BURST_MAX));
      winner     = keep_owner ? last_grant_q : rr_winner;
      // Ready is withheld during reset so an accept in that cycle cannot happen.
      accept     = any_valid && (credits_q != '0) && !rst;
      at_depth   = (credits_q == CNT_W'(DEPTH));
      bus.req_ready = accept ? (NUM_REQ'(1) << winner) : '0;
   end

   // Next-state for grant tracking, the registered write port and credits.
   always_comb begin
      state_d      = S_IDLE;
      last_grant_d = last_grant_q;
      burst_cnt_d  = '0;
      write_en_d   = 1'b0;
      buf_in_d     = buf_in_q;
      grant_id_d   = grant_id_q;
      credits_d    = credits_q;
      credit_err_d = credit_err_q;

      if (accept) begin
         state_d      = S_BURST;
         last_grant_d = winner;
         burst_cnt_d  = ((state_q == S_BURST) && (winner == last_grant_q)) ?
                        burst_cnt_q + BURST_W'(1) : BURST_W'(1);
         write_en_d   = 1'b1;
         buf_in_d     = bus.req_data[int'(winner)*DATA_W +: DATA_W];
         grant_id_d   = winner;
      end

      // A pop with the counter already at DEPTH is a consumer error; saturate.
      if (bus.fifo_pop && at_depth) begin
         credit_err_d = 1'b1;
      end

      case ({accept, bus.fifo_pop})
         2'b10:   credits_d = credits_q - CNT_W'(1);
         2'b01:   credits_d = at_depth ? credits_q : credits_q + CNT_W'(1);
         default: credits_d = credits_q;
      endcase
   end

   // State registers; asynchronous reset returns everything to power-up values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         last_grant_q <= ID_W'(NUM_REQ - 1);
         burst_cnt_q  <= '0;
         credits_q    <= CNT_W'(DEPTH);
         credit_err_q <= 1'b0;
         write_en_q   <= 1'b0;
         buf_in_q     <= '0;
         grant_id_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         burst_cnt_q  <= burst_cnt_d;
         credits_q    <= credits_d;
         credit_err_q <= credit_err_d;
         write_en_q   <= write_en_d;
         buf_in_q     <= buf_in_d;
         grant_id_q   <= grant_id_d;
      end
   end

   assign bus.fifo_write_en = write_en_q;
   assign bus.fifo_buf_in   = buf_in_q;
   assign bus.grant_id      = grant_id_q;
   assign bus.credits       = credits_q;
   assign bus.credit_err    = credit_err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: round-robin, bursts, credits, reset.
module tb_fifo_wr_arbiter;
   import fifo_arb_pkg::*;

   logic clk;
   logic rst;

   int n_tests;
   int n_fail;

   fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_W(8), .CNT_W(7)) bus_rr ();
   fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_W(8), .CNT_W(7)) bus_b  ();

   fifo_wr_arbiter #(
      .NUM_REQ(4), .DATA_W(8), .DEPTH(64), .CNT_W(7), .BURST_MAX(1)
   ) dut_rr (
      .clk (clk),
      .rst (rst),
      .bus (bus_rr)
   );

   fifo_wr_arbiter #(
      .NUM_REQ(4), .DATA_W(8), .DEPTH(64), .CNT_W(7), .BURST_MAX(4)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_data(input int i);
      return 8'hA0 + 8'(8'h11 * i);
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         burst_seq [12];
      int         n_wr;
      logic [7:0] word;
      logic [31:0] data_all;

      n_tests   = 0;
      n_fail    = 0;
      burst_seq = '{2, 2, 2, 2, 3, 3, 3, 3, 2, 2, 2, 2};
      data_all  = {exp_data(3), exp_data(2), exp_data(1), exp_data(0)};

      rst              = 1'b1;
      bus_rr.req_valid = '0;
      bus_rr.req_data  = '0;
      bus_rr.fifo_pop  = 1'b0;
      bus_b.req_valid  = '0;
      bus_b.req_data   = '0;
      bus_b.fifo_pop   = 1'b0;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_ready",   32'(bus_b.req_ready),     32'h0);
      check("rst_wen",     32'(bus_b.fifo_write_en), 32'h0);
      check("rst_buf",     32'(bus_b.fifo_buf_in),   32'h0);
      check("rst_gid",     32'(bus_b.grant_id),      32'h0);
      check("rst_credits", 32'(bus_b.credits),       32'd64);
      check("rst_err",     32'(bus_b.credit_err),    32'h0);
      rst = 1'b0;

      // Round-robin with BURST_MAX = 1
      bus_rr.req_data  = data_all;
      bus_rr.req_valid = 4'hF;
      #1 check("rr_ready0", 32'(bus_rr.req_ready), 32'b0001);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("rr_gid", 32'(bus_rr.grant_id),      32'(k % 4));
         check("rr_wen", 32'(bus_rr.fifo_write_en), 32'h1);
         check("rr_buf", 32'(bus_rr.fifo_buf_in),   32'(exp_data(k % 4)));
      end
      bus_rr.req_valid = '0;
      check("rr_credits", 32'(bus_rr.credits), 32'd56);
      @(negedge clk);
      check("rr_idle_wen", 32'(bus_rr.fifo_write_en), 32'h0);

      // Bursts of four between requesters 2 and 3
      bus_b.req_data  = data_all;
      bus_b.req_valid = 4'b1100;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         check("burst_gid", 32'(bus_b.grant_id),    32'(burst_seq[k]));
         check("burst_buf", 32'(bus_b.fifo_buf_in), 32'(exp_data(burst_seq[k])));
      end
      bus_b.req_valid = '0;
      check("burst_credits", 32'(bus_b.credits), 32'd52);

      // Credit exhaustion from a single streaming producer
      do_reset();
      bus_b.req_valid = 4'b0010;
      n_wr = 0;
      repeat (80) begin
         @(negedge clk);
         if (bus_b.fifo_write_en) n_wr++;
      end
      check("exh_writes",  32'(n_wr),            32'd64);
      check("exh_credits", 32'(bus_b.credits),   32'd0);
      check("exh_ready",   32'(bus_b.req_ready), 32'h0);
      bus_b.fifo_pop = 1'b1;
      @(negedge clk);
      bus_b.fifo_pop = 1'b0;
      check("pop1_credits", 32'(bus_b.credits),   32'd1);
      check("pop1_ready",   32'(bus_b.req_ready), 32'b0010);
      @(negedge clk);
      check("pop1_wen",     32'(bus_b.fifo_write_en), 32'h1);
      check("pop1_empty",   32'(bus_b.credits),       32'd0);
      check("pop1_noready", 32'(bus_b.req_ready),     32'h0);
      bus_b.req_valid = '0;
      @(negedge clk);
      check("pop1_idle", 32'(bus_b.fifo_write_en), 32'h0);

      // Simultaneous accept and pop at credits = 10
      bus_b.fifo_pop = 1'b1;
      repeat (10) @(negedge clk);
      bus_b.fifo_pop = 1'b0;
      check("c10_credits", 32'(bus_b.credits), 32'd10);
      bus_b.req_valid = 4'b0010;
      bus_b.fifo_pop  = 1'b1;
      #1 check("c10_ready", 32'(bus_b.req_ready), 32'b0010);
      @(negedge clk);
      bus_b.req_valid = '0;
      bus_b.fifo_pop  = 1'b0;
      check("c10_wen",  32'(bus_b.fifo_write_en), 32'h1);
      check("c10_hold", 32'(bus_b.credits),       32'd10);

      // Pop while already at DEPTH: saturate and set sticky error
      do_reset();
      bus_b.fifo_pop = 1'b1;
      @(negedge clk);
      bus_b.fifo_pop = 1'b0;
      check("sat_credits", 32'(bus_b.credits),    32'd64);
      check("sat_err",     32'(bus_b.credit_err), 32'h1);
      repeat (5) @(negedge clk);
      check("sat_sticky",  32'(bus_b.credit_err), 32'h1);
      do_reset();
      check("sat_cleared", 32'(bus_b.credit_err), 32'h0);

      // Reset in the middle of a burst to requester 1
      bus_b.req_valid = 4'b0010;
      repeat (2) @(negedge clk);
      check("mid_pre_wen", 32'(bus_b.fifo_write_en), 32'h1);
      check("mid_pre_gid", 32'(bus_b.grant_id),      32'h1);
      rst = 1'b1;
      #1;
      check("mid_ready",   32'(bus_b.req_ready),     32'h0);
      check("mid_wen",     32'(bus_b.fifo_write_en), 32'h0);
      check("mid_buf",     32'(bus_b.fifo_buf_in),   32'h0);
      check("mid_gid",     32'(bus_b.grant_id),      32'h0);
      check("mid_credits", 32'(bus_b.credits),       32'd64);
      check("mid_err",     32'(bus_b.credit_err),    32'h0);
      bus_b.req_valid = 4'hF;
      @(negedge clk);
      rst = 1'b0;
      #1 check("post_ready", 32'(bus_b.req_ready), 32'b0001);
      @(negedge clk);
      check("post_gid", 32'(bus_b.grant_id),      32'h0);
      check("post_wen", 32'(bus_b.fifo_write_en), 32'h1);
      bus_b.req_valid = '0;
      @(negedge clk);

      // Sparse single producer: one word every three cycles
      for (int w = 0; w < 4; w++) begin
         word            = 8'h3C + 8'(w * 37);
         bus_b.req_data  = 32'(word) << 16;
         bus_b.req_valid = 4'b0100;
         #1 check("sp_ready", 32'(bus_b.req_ready), 32'b0100);
         @(negedge clk);
         bus_b.req_valid = '0;
         check("sp_wen", 32'(bus_b.fifo_write_en), 32'h1);
         check("sp_buf", 32'(bus_b.fifo_buf_in),   32'(word));
         check("sp_gid", 32'(bus_b.grant_id),      32'h2);
         @(negedge clk);
         check("sp_gap1", 32'(bus_b.fifo_write_en), 32'h0);
         @(negedge clk);
         check("sp_gap2", 32'(bus_b.fifo_write_en), 32'h0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
